// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster generator: pixel-rate divider, sx/sy counters, frame counter,
// and a one-pixel registered output stage that keeps sync and blanked colour aligned.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_r,
  input  logic [2:0] in_g,
  input  logic [1:0] in_b,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       active,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Keep the divider at least one bit wide so CLK_DIV=1 still elaborates.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div;
  logic          hs_raw;
  logic          vs_raw;

  assign pix_tick    = (div == DIV_LAST);
  assign active      = (sx < H_ACT) && (sy < V_ACT);
  assign frame_start = pix_tick && (sx == 10'd0) && (sy == 10'd0);
  assign hs_raw      = !((sx >= HS_BEG) && (sx <= HS_END));
  assign vs_raw      = !((sy >= VS_BEG) && (sy <= VS_END));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx          <= '0;
      sy          <= '0;
      frame_count <= '0;
    end else if (pix_tick) begin
      if (sx == H_LAST) begin
        sx <= '0;
        if (sy == V_LAST) begin
          sy          <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          sy <= sy + 10'd1;
        end
      end else begin
        sx <= sx + 10'd1;
      end
    end
  end

  // Colour is sampled on the tick that leaves the pixel, so it lands with that pixel's sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (pix_tick) begin
      hsync <= hs_raw;
      vsync <= vs_raw;
      vga_r <= active ? in_r : 3'd0;
      vga_g <= active ? in_g : 3'd0;
      vga_b <= active ? in_b : 2'd0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-width line with a shortened frame at CLK_DIV=4, plus a tiny
// CLK_DIV=1 raster, both compared every clock against an arithmetic tick-count model.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_r = '0;
  logic [2:0] in_g = '0;
  logic [1:0] in_b = '0;

  logic [9:0] sx_m, sy_m, sx_f, sy_f;
  logic       act_m, tick_m, fs_m, hs_m, vs_m;
  logic       act_f, tick_f, fs_f, hs_f, vs_f;
  logic [7:0] fc_m, fc_f;
  logic [2:0] r_m, g_m, r_f, g_f;
  logic [1:0] b_m, b_f;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .sx(sx_m), .sy(sy_m), .active(act_m), .pix_tick(tick_m), .frame_start(fs_m),
    .frame_count(fc_m), .hsync(hs_m), .vsync(vs_m), .vga_r(r_m), .vga_g(g_m), .vga_b(b_m)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .sx(sx_f), .sy(sy_f), .active(act_f), .pix_tick(tick_f), .frame_start(fs_f),
    .frame_count(fc_f), .hsync(hs_f), .vsync(vs_f), .vga_r(r_f), .vga_g(g_f), .vga_b(b_f)
  );

  logic [40:0] vec_main, vec_fast;
  assign vec_main = {sx_m, sy_m, act_m, tick_m, fs_m, fc_m, hs_m, vs_m, r_m, g_m, b_m};
  assign vec_fast = {sx_f, sy_f, act_f, tick_f, fs_f, fc_f, hs_f, vs_f, r_f, g_f, b_f};

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;         // clock edges counted since reset release
  logic [7:0] col_main = '0;
  logic [7:0] col_fast = '0;
  bit rand_col = 1'b1;

  typedef struct {
    int         n;
    logic       tick;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       fs;
  } tick_vec_t;
  tick_vec_t tbl[8];

  // Expected outputs from the number of completed pixel ticks: position is p mod line/frame,
  // registered outputs describe pixel p-1 with the colour captured when it was left.
  function automatic logic [40:0] model(input int nn, input int d,
                                        input int ha, input int hfp, input int hsw, input int hbp,
                                        input int va, input int vfp, input int vsw, input int vbp,
                                        input logic [7:0] col);
    int ht, vt, p, x, y, q, qx, qy;
    logic tk, fs, hsy, vsy, act;
    logic [7:0] c;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    p   = nn / d;
    x   = p % ht;
    y   = (p / ht) % vt;
    tk  = (nn % d) == d - 1;
    act = (x < ha) && (y < va);
    fs  = tk && x == 0 && y == 0;
    hsy = 1'b1;
    vsy = 1'b1;
    c   = '0;
    if (p > 0) begin
      q   = p - 1;
      qx  = q % ht;
      qy  = (q / ht) % vt;
      hsy = !(qx >= ha + hfp && qx < ha + hfp + hsw);
      vsy = !(qy >= va + vfp && qy < va + vfp + vsw);
      if (qx < ha && qy < va) c = col;
    end
    return {10'(x), 10'(y), act, tk, fs, 8'((p / (ht * vt)) % 256), hsy, vsy, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (clk %0d after release)", name, act, exp, n);
    end
  endtask

  task automatic check_all();
    chk("raster_main", 64'(vec_main), 64'(model(n, 4, 640, 16, 96, 48, 4, 1, 2, 1, col_main)));
    chk("raster_fast", 64'(vec_fast), 64'(model(n, 1, 8, 2, 2, 2, 4, 1, 1, 1, col_fast)));
  endtask

  task automatic drive();
    if (rand_col) begin
      in_r = 3'($urandom_range(0, 7));
      in_g = 3'($urandom_range(0, 7));
      in_b = 2'($urandom_range(1, 3));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (n % 4 == 3) col_main = {in_r, in_g, in_b};
      col_fast = {in_r, in_g, in_b};
      n++;
    end
    #1;
    check_all();
    drive();
  endtask

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      while (n < tbl[i].n) step();
      chk($sformatf("tick_table_%0d", i), 64'({tick_m, sx_m, sy_m, fs_m}),
          64'({tbl[i].tick, tbl[i].sx, tbl[i].sy, tbl[i].fs}));
    end
  endtask

  int hl, c_on, c_off, fs_cnt, blank_bad, p;
  int vl[2];

  initial begin
    tbl[0] = '{0,  1'b0, 10'd0, 10'd0, 1'b0};
    tbl[1] = '{2,  1'b0, 10'd0, 10'd0, 1'b0};
    tbl[2] = '{3,  1'b1, 10'd0, 10'd0, 1'b1};
    tbl[3] = '{4,  1'b0, 10'd1, 10'd0, 1'b0};
    tbl[4] = '{7,  1'b1, 10'd1, 10'd0, 1'b0};
    tbl[5] = '{8,  1'b0, 10'd2, 10'd0, 1'b0};
    tbl[6] = '{11, 1'b1, 10'd2, 10'd0, 1'b0};
    tbl[7] = '{12, 1'b0, 10'd3, 10'd0, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("reset_values", 64'({sx_m, sy_m, hs_m, vs_m, r_m, g_m, b_m, fc_m, tick_m, fs_m}),
        64'({10'd0, 10'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0}));
    chk("fast_tick_in_reset", 64'(tick_f), 64'(1'b1));

    rst_n = 1'b1;
    run_table();

    // Constant colour across line 1 to measure blanking and hsync placement.
    rand_col = 1'b0;
    in_r = 3'd7; in_g = 3'd5; in_b = 2'd3;
    while (n < 3199) step();
    chk("line_end", 64'({sx_m, sy_m}), 64'({10'd799, 10'd0}));
    step();
    chk("line_wrap", 64'({sx_m, sy_m}), 64'({10'd0, 10'd1}));
    hl = 0; c_on = 0; c_off = 0;
    while (n < 1600 * 4) begin
      step();
      if (n % 4 == 0) begin
        if (!hs_m) hl++;
        if ({r_m, g_m, b_m} == 8'hF7) c_on++;
        else if ({r_m, g_m, b_m} == 8'h00) c_off++;
        if (sx_m == 10'd656) chk("hs_before_low", 64'(hs_m), 64'(1'b1));
        if (sx_m == 10'd657) chk("hs_first_low", 64'(hs_m), 64'(1'b0));
      end
    end
    chk("hsync_low_ticks", 64'(hl), 64'(96));
    chk("colour_shown_ticks", 64'(c_on), 64'(640));
    chk("colour_blank_ticks", 64'(c_off), 64'(160));

    rand_col = 1'b1;
    fs_cnt = 0; blank_bad = 0; vl[0] = 0; vl[1] = 0;
    while (n < 12800 * 4 + 3) begin
      step();
      if (fs_m) fs_cnt++;
      if (n % 4 == 0) begin
        p = n / 4;
        if (!vs_m) vl[(p - 1) / 6400]++;
        if (((p - 1) / 800) % 8 >= 4 && {r_m, g_m, b_m} != 8'h00) blank_bad++;
      end
      if (n == 6399 * 4) chk("frame_last_pixel", 64'({sx_m, sy_m}), 64'({10'd799, 10'd7}));
      if (n == 6400 * 4) chk("frame_wrap", 64'({sx_m, sy_m, fc_m}), 64'({10'd0, 10'd0, 8'd1}));
    end
    chk("vsync_low_frame0", 64'(vl[0]), 64'(1600));
    chk("vsync_low_frame1", 64'(vl[1]), 64'(1600));
    chk("frame_start_pulses", 64'(fs_cnt), 64'(2));
    chk("frame_count_two", 64'(fc_m), 64'(8'd2));
    chk("vblank_colour", 64'(blank_bad), 64'(0));

    // Reset in the middle of a clock period, at sx=300 on line 2.
    while (n < 14700 * 4 + 1) step();
    chk("pre_reset_pos", 64'({sx_m, sy_m}), 64'({10'd300, 10'd2}));
    #2;
    rst_n = 1'b0;
    n = 0;
    #1;
    chk("async_reset", 64'({sx_m, sy_m, hs_m, vs_m, r_m, g_m, b_m, fc_m, tick_m, fs_m}),
        64'({10'd0, 10'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 8'd0, 1'b0, 1'b0}));
    check_all();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    run_table();
    chk("frame_count_after_reset", 64'(fc_m), 64'(8'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
